// File: rtl/multi_queue_pkg.sv
// Shared helpers for the multi-queue FIFO and its round-robin reader.
// Width functions and the wrapping round-robin successor.
package multi_queue_pkg;

    function automatic int qid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int rr_next(input int cur, input int n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at/after
// the rotating pointer, which moves past the winner on each grant.
module rr_arbiter
    import multi_queue_pkg::*;
#(
    parameter int N = 4,
    localparam int PW = qid_width(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         grant_valid
);

    logic [PW-1:0] ptr;
    logic [PW-1:0] scan;
    logic [PW-1:0] grant_idx;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan        = ptr;
        for (int i = 0; i < N; i++) begin
            if (!grant_valid && req[scan]) begin
                grant[scan] = 1'b1;
                grant_valid = 1'b1;
                grant_idx   = scan;
            end
            scan = PW'(rr_next(int'(scan), N));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_valid) begin
            ptr <= PW'(rr_next(int'(grant_idx), N));
        end
    end

endmodule

// File: rtl/multi_queue_rr_fifo.sv
// Multi-queue FIFO: demuxed write stream into per-queue circular buffers,
// one round-robin storage read per cycle refills per-queue output registers.
module multi_queue_rr_fifo
    import multi_queue_pkg::*;
#(
    parameter int QUEUE_COUNT  = 4,
    parameter int DEPTH        = 8,
    parameter int DATA_WIDTH   = 32,
    parameter int AF_THRESHOLD = 6,
    localparam int QW = qid_width(QUEUE_COUNT),
    localparam int LW = level_width(DEPTH)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    input  logic [QW-1:0]                     in_target,
    input  logic [DATA_WIDTH-1:0]             in_data,
    output logic [QUEUE_COUNT-1:0]            in_ready,
    output logic [QUEUE_COUNT-1:0]            out_valid,
    output logic [QUEUE_COUNT*DATA_WIDTH-1:0] out_data,
    input  logic [QUEUE_COUNT-1:0]            out_ready,
    output logic [QUEUE_COUNT*LW-1:0]         level,
    output logic [QUEUE_COUNT-1:0]            almost_full,
    input  logic [QUEUE_COUNT-1:0]            flush
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0]  mem [QUEUE_COUNT][DEPTH];
    logic [LW-1:0]          wr_ptr [QUEUE_COUNT];
    logic [LW-1:0]          rd_ptr [QUEUE_COUNT];
    logic [LW-1:0]          fill [QUEUE_COUNT];
    logic [DATA_WIDTH-1:0]  dout [QUEUE_COUNT];
    logic [QUEUE_COUNT-1:0] wr_en;
    logic [QUEUE_COUNT-1:0] req;
    logic [QUEUE_COUNT-1:0] grant;
    logic                   grant_valid;

    // Pointers carry one extra wrap bit, so the difference is the fill level.
    for (genvar q = 0; q < QUEUE_COUNT; q++) begin : g_q
        assign fill[q]        = wr_ptr[q] - rd_ptr[q];
        assign in_ready[q]    = fill[q] != LW'(DEPTH);
        assign almost_full[q] = fill[q] >= LW'(AF_THRESHOLD);
        assign wr_en[q]       = in_valid && (in_target == QW'(q))
                                && in_ready[q] && !flush[q];
        assign req[q]         = (fill[q] != '0)
                                && (!out_valid[q] || out_ready[q])
                                && !flush[q];
        assign level[q*LW +: LW] = fill[q];
        assign out_data[q*DATA_WIDTH +: DATA_WIDTH] = dout[q];
    end

    rr_arbiter #(
        .N(QUEUE_COUNT)
    ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .grant      (grant),
        .grant_valid(grant_valid)
    );

    always_ff @(posedge clk) begin
        for (int q = 0; q < QUEUE_COUNT; q++) begin
            if (wr_en[q]) begin
                mem[q][wr_ptr[q][AW-1:0]] <= in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int q = 0; q < QUEUE_COUNT; q++) begin
                wr_ptr[q] <= '0;
                rd_ptr[q] <= '0;
                dout[q]   <= '0;
            end
            out_valid <= '0;
        end else begin
            for (int q = 0; q < QUEUE_COUNT; q++) begin
                if (flush[q]) begin
                    wr_ptr[q]    <= '0;
                    rd_ptr[q]    <= '0;
                    out_valid[q] <= 1'b0;
                end else begin
                    if (wr_en[q]) begin
                        wr_ptr[q] <= wr_ptr[q] + LW'(1);
                    end
                    if (grant_valid && grant[q]) begin
                        rd_ptr[q]    <= rd_ptr[q] + LW'(1);
                        dout[q]      <= mem[q][rd_ptr[q][AW-1:0]];
                        out_valid[q] <= 1'b1;
                    end else if (out_ready[q]) begin
                        out_valid[q] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_queue_rr_fifo.sv
// Directed bench for multi_queue_rr_fifo: latency, fill/almost-full,
// round-robin drain, output stall, flush and asynchronous reset.
module tb_multi_queue_rr_fifo;

    localparam int QC = 4;
    localparam int DW = 32;
    localparam int LW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic [1:0]     in_target = '0;
    logic [DW-1:0]  in_data = '0;
    logic [QC-1:0]  in_ready;
    logic [QC-1:0]  out_valid;
    logic [QC*DW-1:0] out_data;
    logic [QC-1:0]  out_ready = '0;
    logic [QC*LW-1:0] level;
    logic [QC-1:0]  almost_full;
    logic [QC-1:0]  flush = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_queue_rr_fifo dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_target  (in_target),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .level      (level),
        .almost_full(almost_full),
        .flush      (flush)
    );

    function automatic logic [31:0] lvl(input int q);
        return 32'(level[q*LW +: LW]);
    endfunction

    function automatic logic [31:0] od(input int q);
        return out_data[q*DW +: DW];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int q, input logic [31:0] d);
        in_valid  = 1'b1;
        in_target = 2'(q);
        in_data   = d;
        step();
        in_valid  = 1'b0;
    endtask

    initial begin
        // reset state
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 'hF);
        chk("rst_out_valid", 32'(out_valid), 'h0);
        chk("rst_level", 32'(level), 'h0);
        chk("rst_af", 32'(almost_full), 'h0);
        chk("rst_out_data", 32'(|out_data), 'h0);
        rst_n = 1'b1;
        step();

        // single word latency into q2
        wr(2, 32'hA5);
        chk("t1_level_acc", lvl(2), 1);
        chk("t1_ov_acc", 32'(out_valid), 'h0);
        step();
        chk("t1_ov", 32'(out_valid), 'h4);
        chk("t1_data", od(2), 32'hA5);
        chk("t1_level", lvl(2), 0);
        out_ready = 4'b0100;
        step();
        chk("t1_drain", 32'(out_valid), 'h0);
        out_ready = '0;

        // fill q1: one word parked in the output register, then 8 in storage
        wr(1, 32'h1FF);
        chk("t2_pre_level", lvl(1), 1);
        for (int i = 0; i < 9; i++) begin
            wr(1, 32'h100 + 32'(i));
            chk($sformatf("t2_level_%0d", i), lvl(1), (i < 8) ? i + 1 : 8);
            chk($sformatf("t2_af_%0d", i), 32'(almost_full),
                (i >= 5) ? 'h2 : 'h0);
            chk($sformatf("t2_ready_%0d", i), 32'(in_ready),
                (i >= 7) ? 'hD : 'hF);
        end
        chk("t2_out_data", od(1), 32'h1FF);
        chk("t2_out_valid", 32'(out_valid), 'h2);

        flush = 4'b0010;
        step();
        flush = '0;
        chk("fl1_level", 32'(level), 'h0);
        chk("fl1_ov", 32'(out_valid), 'h0);
        chk("fl1_ready", 32'(in_ready), 'hF);

        // all queues loaded, round-robin drain
        wr(0, 32'hA0); wr(0, 32'hA1);
        wr(1, 32'hB0); wr(1, 32'hB1);
        wr(2, 32'hC0); wr(2, 32'hC1);
        wr(3, 32'hD0); wr(3, 32'hD1);
        chk("t3_ov_load", 32'(out_valid), 'hF);
        chk("t3_level_load", 32'(level), 'h1111);
        out_ready = 4'hF;
        step();
        chk("t3_g0_ov", 32'(out_valid), 'h1);
        chk("t3_g0_data", od(0), 32'hA1);
        step();
        chk("t3_g1_ov", 32'(out_valid), 'h2);
        chk("t3_g1_data", od(1), 32'hB1);
        step();
        chk("t3_g2_ov", 32'(out_valid), 'h4);
        chk("t3_g2_data", od(2), 32'hC1);
        step();
        chk("t3_g3_ov", 32'(out_valid), 'h8);
        chk("t3_g3_data", od(3), 32'hD1);
        step();
        chk("t3_empty", 32'(out_valid), 'h0);

        // q0 stalled while q1..q3 drain
        out_ready = '0;
        wr(0, 32'hE0); wr(0, 32'hE1);
        wr(1, 32'hF0); wr(1, 32'hF1); wr(1, 32'hF2);
        wr(2, 32'h60); wr(2, 32'h61);
        wr(3, 32'h70);
        step();
        chk("t4_ov_load", 32'(out_valid), 'hF);
        chk("t4_level_load", 32'(level), 'h0121);
        out_ready = 4'b1110;
        for (int c = 1; c <= 10; c++) begin
            step();
            chk($sformatf("t4_hold_%0d", c), od(0), 32'hE0);
            chk($sformatf("t4_ov0_%0d", c), 32'(out_valid[0]), 1);
            if (c == 1) begin
                chk("t4_c1_ov", 32'(out_valid), 'h3);
                chk("t4_c1_data", od(1), 32'hF1);
            end
            if (c == 2) begin
                chk("t4_c2_ov", 32'(out_valid), 'h5);
                chk("t4_c2_data", od(2), 32'h61);
            end
            if (c == 3) begin
                chk("t4_c3_ov", 32'(out_valid), 'h3);
                chk("t4_c3_data", od(1), 32'hF2);
            end
        end
        chk("t4_end_ov", 32'(out_valid), 'h1);
        chk("t4_end_level", 32'(level), 'h0001);
        out_ready = 4'b0001;
        step();
        chk("t4_release_data", od(0), 32'hE1);
        chk("t4_release_ov", 32'(out_valid), 'h1);
        step();
        chk("t4_release_end", 32'(out_valid), 'h0);
        out_ready = '0;

        // write and flush q3 in the same cycle
        wr(3, 32'h30); wr(3, 32'h31); wr(3, 32'h32); wr(3, 32'h33);
        chk("t5_level_pre", lvl(3), 3);
        chk("t5_ov_pre", 32'(out_valid), 'h8);
        in_valid  = 1'b1;
        in_target = 2'd3;
        in_data   = 32'hCC;
        flush     = 4'b1000;
        chk("t5_ready", 32'(in_ready[3]), 1);
        step();
        in_valid = 1'b0;
        flush    = '0;
        chk("t5_level", lvl(3), 0);
        chk("t5_ov", 32'(out_valid), 'h0);
        step();
        step();
        chk("t5_quiet_ov", 32'(out_valid), 'h0);
        chk("t5_quiet_level", 32'(level), 'h0);

        // asynchronous reset mid-burst
        out_ready = 4'hF;
        wr(0, 32'h40); wr(0, 32'h41);
        in_valid  = 1'b1;
        in_target = 2'd0;
        in_data   = 32'h42;
        step();
        chk("t6_pre_ov", 32'(out_valid[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_ov", 32'(out_valid), 'h0);
        chk("t6_ready", 32'(in_ready), 'hF);
        chk("t6_level", 32'(level), 'h0);
        chk("t6_af", 32'(almost_full), 'h0);
        chk("t6_data", 32'(|out_data), 'h0);
        in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        chk("t6_post_ov", 32'(out_valid), 'h0);
        chk("t6_post_level", 32'(level), 'h0);
        out_ready = '0;
        wr(2, 32'h5A);
        chk("t6_wr_level", lvl(2), 1);
        step();
        chk("t6_wr_ov", 32'(out_valid), 'h4);
        chk("t6_wr_data", od(2), 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
